// File: rtl/line_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : line_packetizer
// Description : Frames captured print-head lines into "LINE:<payload>:" byte
//               packets for the UART TX FIFO. The packet engine holds one
//               active line and one pending line, and stalls while the FIFO
//               is full. Define LINE_PACKETIZER_CHECKSUM_EN to append an XOR
//               checksum byte after the trailer.
// Revision    : 1.0 - initial release
// ============================================================================
module line_packetizer #(
    parameter int HEAD_WIDTH = 384,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  line_valid,
    input  logic [HEAD_WIDTH-1:0] line_data,
    input  logic                  fifo_full,
    output logic                  fifo_write_enable,
    output logic [7:0]            fifo_write_data,
    output logic                  busy,
    output logic [STAT_WIDTH-1:0] line_count,
    output logic [STAT_WIDTH-1:0] drop_count
);

    localparam int c_num_bytes = HEAD_WIDTH / 8;
    localparam int c_idx_max   = (c_num_bytes > 5) ? c_num_bytes : 5;
    localparam int c_idx_w     = $clog2(c_idx_max);

    generate
        if ((HEAD_WIDTH % 8 != 0) || (HEAD_WIDTH < 8)) begin : g_bad_width
            $error("line_packetizer: HEAD_WIDTH must be a multiple of 8 and >= 8");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_PAYLOAD = 3'd2,
`ifdef LINE_PACKETIZER_CHECKSUM_EN
        S_TRAILER = 3'd3,
        S_CHECKSUM = 3'd4
`else
        S_TRAILER = 3'd3
`endif
    } state_t;

    state_t                  state_q,      state_d;
    logic [c_idx_w-1:0]      idx_q,        idx_d;
    logic [HEAD_WIDTH-1:0]   active_q,     active_d;
    logic [HEAD_WIDTH-1:0]   pending_q,    pending_d;
    logic                    pend_full_q,  pend_full_d;
    logic [STAT_WIDTH-1:0]   line_count_q, line_count_d;
    logic [STAT_WIDTH-1:0]   drop_count_q, drop_count_d;

    logic                    w_write;
    logic                    w_last;
    logic [7:0]              w_byte;

    assign w_write = (state_q != S_IDLE) && !fifo_full;

`ifdef LINE_PACKETIZER_CHECKSUM_EN
    logic [7:0] w_csum;

    always_comb begin
        w_csum = 8'h00;
        for (int i = 0; i < c_num_bytes; i++) begin
            w_csum = w_csum ^ active_q[8*i +: 8];
        end
    end

    assign w_last = w_write && (state_q == S_CHECKSUM);
`else
    assign w_last = w_write && (state_q == S_TRAILER);
`endif

    always_comb begin
        w_byte = 8'h00;
        case (state_q)
            S_HEADER: begin
                case (idx_q)
                    c_idx_w'(0): w_byte = 8'h4C;
                    c_idx_w'(1): w_byte = 8'h49;
                    c_idx_w'(2): w_byte = 8'h4E;
                    c_idx_w'(3): w_byte = 8'h45;
                    default:     w_byte = 8'h3A;
                endcase
            end
            S_PAYLOAD:  w_byte = active_q[8*int'(idx_q) +: 8];
            S_TRAILER:  w_byte = 8'h3A;
`ifdef LINE_PACKETIZER_CHECKSUM_EN
            S_CHECKSUM: w_byte = w_csum;
`endif
            default:    w_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        active_d     = active_q;
        pending_d    = pending_q;
        pend_full_d  = pend_full_q;
        line_count_d = line_count_q;
        drop_count_d = drop_count_q;

        if (state_q == S_IDLE) begin
            if (line_valid) begin
                active_d = line_data;
                state_d  = S_HEADER;
                idx_d    = '0;
            end
        end else if (w_last) begin
            // Packet done: chain straight into the next line without an idle gap.
            line_count_d = line_count_q + 1'b1;
            idx_d        = '0;
            if (pend_full_q) begin
                active_d = pending_q;
                state_d  = S_HEADER;
                if (line_valid) begin
                    pending_d = line_data;
                end else begin
                    pend_full_d = 1'b0;
                end
            end else if (line_valid) begin
                active_d = line_data;
                state_d  = S_HEADER;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            if (line_valid) begin
                if (!pend_full_q) begin
                    pending_d   = line_data;
                    pend_full_d = 1'b1;
                end else if (drop_count_q != '1) begin
                    drop_count_d = drop_count_q + 1'b1;
                end
            end
            if (w_write) begin
                idx_d = idx_q + 1'b1;
                case (state_q)
                    S_HEADER: begin
                        if (idx_q == c_idx_w'(4)) begin
                            state_d = S_PAYLOAD;
                            idx_d   = '0;
                        end
                    end
                    S_PAYLOAD: begin
                        if (idx_q == c_idx_w'(c_num_bytes - 1)) begin
                            state_d = S_TRAILER;
                            idx_d   = '0;
                        end
                    end
`ifdef LINE_PACKETIZER_CHECKSUM_EN
                    S_TRAILER: begin
                        state_d = S_CHECKSUM;
                        idx_d   = '0;
                    end
`endif
                    default: idx_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            active_q     <= '0;
            pending_q    <= '0;
            pend_full_q  <= 1'b0;
            line_count_q <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_full_q  <= pend_full_d;
            line_count_q <= line_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign fifo_write_enable = w_write;
    assign fifo_write_data   = w_byte;
    assign busy              = (state_q != S_IDLE) || pend_full_q;
    assign line_count        = line_count_q;
    assign drop_count        = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_line_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_packetizer
// Description : Scoreboard bench for line_packetizer with a packet-level
//               reference model driven by directed and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_packetizer;

    localparam int HW = 16;
    localparam int SW = 16;
    localparam int NB = HW / 8;
`ifdef LINE_PACKETIZER_CHECKSUM_EN
    localparam int PK = NB + 7;
`else
    localparam int PK = NB + 6;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          line_valid = 1'b0;
    logic [HW-1:0] line_data = '0;
    logic          fifo_full = 1'b0;
    logic          fifo_write_enable;
    logic [7:0]    fifo_write_data;
    logic          busy;
    logic [SW-1:0] line_count;
    logic [SW-1:0] drop_count;

    line_packetizer #(.HEAD_WIDTH(HW), .STAT_WIDTH(SW)) dut (
        .clk               (clk),
        .reset             (reset),
        .line_valid        (line_valid),
        .line_data         (line_data),
        .fifo_full         (fifo_full),
        .fifo_write_enable (fifo_write_enable),
        .fifo_write_data   (fifo_write_data),
        .busy              (busy),
        .line_count        (line_count),
        .drop_count        (drop_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: number of lines held (active + pending) and bytes left
    // in the packet currently being sent.
    logic [7:0]    exp_q[$];
    int            occ  = 0;
    int            left = 0;
    logic [SW-1:0] m_lc = '0;
    logic [SW-1:0] m_dc = '0;

    bit            chk_en   = 1'b0;
    bit            chk_busy = 1'b0;
    logic [SW-1:0] chk_lc   = '0;
    logic [SW-1:0] chk_dc   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void push_pkt(input logic [HW-1:0] d);
        logic [7:0] cs;
        cs = 8'h00;
        exp_q.push_back(8'h4C);
        exp_q.push_back(8'h49);
        exp_q.push_back(8'h4E);
        exp_q.push_back(8'h45);
        exp_q.push_back(8'h3A);
        for (int i = 0; i < NB; i++) begin
            exp_q.push_back(d[8*i +: 8]);
            cs = cs ^ d[8*i +: 8];
        end
        exp_q.push_back(8'h3A);
`ifdef LINE_PACKETIZER_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
    endfunction

    // Drives one clock cycle of inputs and advances the model to the state
    // the DUT holds after the next rising edge.
    task automatic step(input logic lv, input logic [HW-1:0] d, input logic full, input logic rst);
        bit wr, lst, acc;
        @(posedge clk);
        #1;
        line_valid = lv;
        line_data  = d;
        fifo_full  = full;
        reset      = rst;
        chk_busy   = (occ > 0);
        chk_lc     = m_lc;
        chk_dc     = m_dc;
        if (rst) begin
            occ  = 0;
            left = 0;
            m_lc = '0;
            m_dc = '0;
            exp_q.delete();
        end else begin
            wr  = (occ > 0) && !full;
            lst = wr && (left == 1);
            acc = lv && ((occ < 2) || lst);
            if (wr) begin
                left--;
                if (lst) begin
                    occ--;
                    m_lc++;
                end
            end
            if (acc) begin
                push_pkt(d);
                occ++;
            end else if (lv && (m_dc != '1)) begin
                m_dc++;
            end
            if ((occ > 0) && (left == 0)) left = PK;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (occ == 0) break;
            step(1'b0, '0, 1'b0, 1'b0);
        end
        if (occ != 0) check("drain_timeout", 32'(occ), 32'd0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compares outputs against the model away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(chk_busy));
            check("line_count", 32'(line_count), 32'(chk_lc));
            check("drop_count", 32'(drop_count), 32'(chk_dc));
            check("write_enable", 32'(fifo_write_enable), 32'(chk_busy && !fifo_full));
            if (fifo_write_enable) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(fifo_write_data), 32'hFFFF_FFFF);
                end else begin
                    check("write_data", 32'(fifo_write_data), 32'(exp_q.pop_front()));
                end
            end else if (!chk_busy) begin
                check("idle_data", 32'(fifo_write_data), 32'h0);
            end
        end
    end

    initial begin
        bit fired;
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk_en = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);

        // Single line, free-running FIFO
        step(1'b1, 16'hA55A, 1'b0, 1'b0);
        drain();

        // Same line with a 3-cycle FIFO-full stall after the second byte
        step(1'b1, 16'hA55A, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        drain();

        // Three strobes two cycles apart: third one is dropped
        step(1'b1, 16'h0001, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 16'h0002, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 16'h0003, 1'b0, 1'b0);
        drain();

        // Strobe coincident with the last byte while pending is occupied
        step(1'b1, 16'h0F0F, 1'b0, 1'b0);
        step(1'b1, 16'h1111, 1'b0, 1'b0);
        fired = 1'b0;
        for (int i = 0; i < 40 && !fired; i++) begin
            fired = (occ > 0) && (left == 1);
            step(fired, 16'h2222, 1'b0, 1'b0);
        end
        check("coincident_strobe_issued", 32'(fired), 32'd1);
        drain();

        // Reset mid-payload, then a fresh packet
        step(1'b1, 16'hBEEF, 1'b0, 1'b0);
        repeat (6) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 16'hC0DE, 1'b0, 1'b0);
        drain();

        // Random traffic with backpressure, biased toward last-byte strobes
        for (int i = 0; i < 3000; i++) begin
            logic lv, ff;
            logic [HW-1:0] d;
            d  = HW'($urandom);
            ff = ($urandom_range(0, 3) == 0);
            if ((occ > 0) && (left == 1) && !ff && ($urandom_range(0, 1) == 1))
                lv = 1'b1;
            else
                lv = ($urandom_range(0, 5) == 0);
            if (i == 1500) step(1'b0, '0, 1'b1, 1'b1);
            else           step(lv, d, ff, 1'b0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
